// File: rtl/data_mem_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : data_mem_arb_pkg                                     |
// | Description : Shared types and constants for the data-memory       |
// |               arbiter (FSM states, port index, alignment width).   |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Index of a requester: 0 = load/store unit, 1 = DMA/debug port.
  typedef logic port_t;

  // Low address bits that must be zero for a word access.
  localparam int ALIGN_BITS = 2;

  // True when the byte offset inside the word is non-zero.
  function automatic logic is_misaligned(input logic [ALIGN_BITS-1:0] lsb);
    return |lsb;
  endfunction

endpackage : data_mem_arb_pkg
`default_nettype wire

// File: rtl/data_mem_arbiter_rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : rr_arb2                                              |
// | Description : Two-way round-robin arbiter. Single requester always |
// |               wins; on a tie the port that did not win last time   |
// |               is chosen.                                           |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module rr_arb2
  import data_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  port_t last_grant_q;
  port_t last_grant_d;

  // Winner selection and round-robin pointer update.
  always_comb begin
    gnt          = 2'b00;
    last_grant_d = last_grant_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant_q == 1'b1) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    // Pointer only moves when the grant is actually taken.
    if (advance && (|gnt)) begin
      last_grant_d = gnt[1];
    end
  end

  // Pointer register; resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : data_mem_arbiter                                     |
// | Description : Shares one single-port data memory between the LSU   |
// |               (port 0) and the DMA/debug port (port 1). Round-robin|
// |               req/gnt, IDLE->ACCESS->RESP, misaligned words are    |
// |               rejected without touching the memory.                |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_SIZE  = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_SIZE-1:0]  p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_done,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_err,

  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_SIZE-1:0]  p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_done,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_err,

  output logic                  mem_read_en,
  output logic                  mem_write_en,
  output logic [ADDR_SIZE-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  state_t                  state_q,     state_d;
  port_t                   cmd_port_q,  cmd_port_d;
  logic                    cmd_we_q,    cmd_we_d;
  logic [ADDR_SIZE-1:0]    cmd_addr_q,  cmd_addr_d;
  logic [DATA_WIDTH-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q,     rdata_d;
  logic                    err_q,       err_d;

  logic [1:0]              arb_gnt;
  logic                    in_idle;
  logic                    in_access;
  logic                    in_resp;

  logic                    sel_we;
  logic [ADDR_SIZE-1:0]    sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  assign in_idle   = (state_q == IDLE);
  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({p1_req, p0_req}),
    .advance (in_idle),
    .gnt     (arb_gnt)
  );

  // Mux the winning requester's command fields.
  always_comb begin
    sel_we    = p0_we;
    sel_addr  = p0_addr;
    sel_wdata = p0_wdata;
    if (arb_gnt[1]) begin
      sel_we    = p1_we;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
    end
  end

  // Next-state and command capture for the IDLE/ACCESS/RESP sequence.
  always_comb begin
    state_d     = state_q;
    cmd_port_d  = cmd_port_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (|arb_gnt) begin
          cmd_port_d = arb_gnt[1];
          cmd_we_d   = sel_we;
          rdata_d    = '0;
          if (is_misaligned(sel_addr[ALIGN_BITS-1:0])) begin
            // Address/data stay untouched so the memory bus keeps its
            // last driven values while the error is reported.
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            cmd_addr_d  = sel_addr;
            cmd_wdata_d = sel_wdata;
            err_d       = 1'b0;
            state_d     = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!cmd_we_q) begin
          rdata_d = mem_read_data;
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and command registers; async reset aborts any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_port_q  <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_port_q  <= cmd_port_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Requester-side outputs: grants only in IDLE, responses only in RESP.
  always_comb begin
    p0_gnt   = arb_gnt[0] && in_idle;
    p1_gnt   = arb_gnt[1] && in_idle;
    p0_done  = in_resp && (cmd_port_q == 1'b0);
    p1_done  = in_resp && (cmd_port_q == 1'b1);
    p0_rdata = p0_done ? rdata_q : '0;
    p1_rdata = p1_done ? rdata_q : '0;
    p0_err   = p0_done && err_q;
    p1_err   = p1_done && err_q;
  end

  // Memory-side outputs: strobes only during the single ACCESS cycle.
  always_comb begin
    mem_read_en    = in_access && !cmd_we_q;
    mem_write_en   = in_access &&  cmd_we_q;
    mem_addr       = cmd_addr_q;
    mem_write_data = cmd_wdata_q;
  end

endmodule : data_mem_arbiter
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_data_mem_arbiter                                  |
// | Description : Directed self-checking bench for data_mem_arbiter    |
// |               with a small behavioural data memory.                |
// | Revision    : 1.0  initial release                                 |
// +--------------------------------------------------------------------+
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_req, p0_we, p0_gnt, p0_done, p0_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_gnt, p1_done, p1_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;

  logic [31:0] mem [0:63];
  int          rd_cnt;
  int          wr_cnt;
  int          tests;
  int          failed;
  int          rd_snap;
  int          wr_snap;

  data_mem_arbiter #(.ADDR_SIZE(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-indexed memory model with combinational read.
  assign mem_read_data = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr[7:2]] <= mem_write_data;
    if (mem_read_en)  rd_cnt <= rd_cnt + 1;
    if (mem_write_en) wr_cnt <= wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0; failed = 0; rd_cnt = 0; wr_cnt = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[32'h10 >> 2] = 32'hDEADBEEF;
    mem[32'h30 >> 2] = 32'hAAAA5555;
    idle_inputs();
    rst_n = 1'b0;
    edge1(); edge1();

    // Reset state
    chk("rst_p0_gnt",  p0_gnt,  0);
    chk("rst_p1_done", p1_done, 0);
    chk("rst_p0_rdata", p0_rdata, 0);
    chk("rst_mem_rd",  mem_read_en, 0);
    chk("rst_mem_wr",  mem_write_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    edge1();

    // Single read by p0
    p0_req = 1; p0_we = 0; p0_addr = 32'h10; #1;
    chk("rd_p0_gnt", p0_gnt, 1);
    chk("rd_p1_gnt", p1_gnt, 0);
    chk("rd_T_mem_rd", mem_read_en, 0);
    edge1(); p0_req = 0; #1;
    chk("rd_T1_mem_rd", mem_read_en, 1);
    chk("rd_T1_mem_wr", mem_write_en, 0);
    chk("rd_T1_addr", mem_addr, 32'h10);
    chk("rd_T1_gnt", p0_gnt, 0);
    edge1();
    chk("rd_T2_done", p0_done, 1);
    chk("rd_T2_rdata", p0_rdata, 32'hDEADBEEF);
    chk("rd_T2_err", p0_err, 0);
    chk("rd_T2_mem_rd", mem_read_en, 0);
    edge1();
    chk("rd_T3_done", p0_done, 0);

    // p1 write then read back
    wr_snap = wr_cnt;
    p1_req = 1; p1_we = 1; p1_addr = 32'h20; p1_wdata = 32'h12345678; #1;
    chk("wr_p1_gnt", p1_gnt, 1);
    edge1(); p1_req = 0; #1;
    chk("wr_mem_wr", mem_write_en, 1);
    chk("wr_mem_wdata", mem_write_data, 32'h12345678);
    chk("wr_mem_addr", mem_addr, 32'h20);
    edge1();
    chk("wr_mem_wr_off", mem_write_en, 0);
    chk("wr_p1_done", p1_done, 1);
    chk("wr_p1_rdata", p1_rdata, 0);
    chk("wr_p0_done", p0_done, 0);
    chk("wr_count", wr_cnt - wr_snap, 1);
    edge1();
    p1_req = 1; p1_we = 0; p1_addr = 32'h20; #1;
    chk("rb_p1_gnt", p1_gnt, 1);
    edge1(); p1_req = 0; #1;
    edge1();
    chk("rb_p1_done", p1_done, 1);
    chk("rb_p1_rdata", p1_rdata, 32'h12345678);
    chk("rb_p0_done", p0_done, 0);
    chk("rb_p0_rdata", p0_rdata, 0);
    chk("rb_p0_err", p0_err, 0);
    edge1();

    // Contention from reset: grants 0,1,0,1 three cycles apart
    rst_n = 1'b0; edge1(); rst_n = 1'b1; edge1();
    p0_req = 1; p0_we = 0; p0_addr = 32'h10;
    p1_req = 1; p1_we = 0; p1_addr = 32'h20;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk($sformatf("ct_p0_gnt_%0d", k), p0_gnt, (k % 6) == 0);
      chk($sformatf("ct_p1_gnt_%0d", k), p1_gnt, (k % 6) == 3);
      chk($sformatf("ct_p0_done_%0d", k), p0_done, (k % 6) == 2);
      chk($sformatf("ct_p1_done_%0d", k), p1_done, (k % 6) == 5);
      edge1();
    end
    idle_inputs();
    edge1();

    // Misaligned p0 read: error response, no memory activity
    rd_snap = rd_cnt; wr_snap = wr_cnt;
    p0_req = 1; p0_we = 0; p0_addr = 32'h13; #1;
    chk("mis_gnt", p0_gnt, 1);
    chk("mis_T_mem_rd", mem_read_en, 0);
    edge1(); p0_req = 0; #1;
    chk("mis_done", p0_done, 1);
    chk("mis_err", p0_err, 1);
    chk("mis_rdata", p0_rdata, 0);
    chk("mis_mem_rd", mem_read_en, 0);
    chk("mis_mem_wr", mem_write_en, 0);
    chk("mis_addr_hold", mem_addr, 32'h20);
    edge1();
    chk("mis_done_off", p0_done, 0);
    chk("mis_err_off", p0_err, 0);
    chk("mis_rd_count", rd_cnt - rd_snap, 0);
    chk("mis_wr_count", wr_cnt - wr_snap, 0);

    // Reset during ACCESS of a p1 write to 0x30
    p1_req = 1; p1_we = 1; p1_addr = 32'h30; p1_wdata = 32'h11112222; #1;
    chk("ra_gnt", p1_gnt, 1);
    edge1(); p1_req = 0; #1;
    chk("ra_access_wr", mem_write_en, 1);
    #1; rst_n = 1'b0; #1;
    chk("ra_async_wr", mem_write_en, 0);
    chk("ra_async_addr", mem_addr, 0);
    chk("ra_async_wdata", mem_write_data, 0);
    edge1();
    chk("ra_no_done", p1_done, 0);
    rst_n = 1'b1;
    edge1();
    chk("ra_idle_done", p1_done, 0);
    p1_req = 1; p1_we = 0; p1_addr = 32'h30; #1;
    chk("ra_rb_gnt", p1_gnt, 1);
    edge1(); p1_req = 0; #1;
    edge1();
    chk("ra_rb_done", p1_done, 1);
    chk("ra_rb_rdata", p1_rdata, 32'hAAAA5555);
    edge1();

    // Withdrawal: p1 requests during p0's ACCESS and drops before IDLE
    rd_snap = rd_cnt; wr_snap = wr_cnt;
    p0_req = 1; p0_we = 0; p0_addr = 32'h10; #1;
    chk("wd_p0_gnt", p0_gnt, 1);
    edge1(); p0_req = 0;
    p1_req = 1; p1_we = 1; p1_addr = 32'h30; p1_wdata = 32'h0; #1;
    chk("wd_access_p1_gnt", p1_gnt, 0);
    edge1();
    chk("wd_resp_p1_gnt", p1_gnt, 0);
    chk("wd_resp_p0_done", p0_done, 1);
    p1_req = 0; #1;
    edge1();
    chk("wd_idle_p1_gnt", p1_gnt, 0);
    edge1();
    chk("wd_idle2_p1_gnt", p1_gnt, 0);
    chk("wd_p1_done", p1_done, 0);
    chk("wd_wr_count", wr_cnt - wr_snap, 0);
    chk("wd_rd_count", rd_cnt - rd_snap, 1);
    chk("wd_mem30", mem[32'h30 >> 2], 32'hAAAA5555);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_data_mem_arbiter
`default_nettype wire
